// File: rtl/pic_pkg.sv
// Shared types and encodings for the 8259A-compatible PIC command path.
// Used by the bus strobe decoder and the command sequencer.
package pic_pkg;

    typedef enum logic [2:0] {
        UNINIT    = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } pic_state_t;

    localparam logic [1:0] RD_IRR  = 2'd0;
    localparam logic [1:0] RD_ISR  = 2'd1;
    localparam logic [1:0] RD_IMR  = 2'd2;
    localparam logic [1:0] RD_POLL = 2'd3;

    // OCW2 {R, SL, EOI} command codes
    localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
    localparam logic [2:0] OCW2_NOP          = 3'b010;
    localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
    localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
    localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

endpackage

// File: rtl/pic_bus_strobe.sv
// CPU strobe decoder: one write event per WR_n low phase, registered read level.
// wr_evt is combinational from the inputs; rd_flag lags cs_n/rd_n by one cycle.
module pic_bus_strobe (
    input  logic clk,
    input  logic reset,
    input  logic cs_n,
    input  logic rd_n,
    input  logic wr_n,
    output logic wr_evt,
    output logic rd_req,
    output logic rd_flag
);

    logic wr_n_q, wr_n_d;
    logic wr_arm_q, wr_arm_d;
    logic rd_flag_q, rd_flag_d;

    // A write concurrent with a read wins; the read level is suppressed.
    assign rd_req = !cs_n && !rd_n && wr_n;

    // wr_arm_q stays low until WR_n is seen high, so a strobe already low
    // when reset lifts cannot masquerade as a fresh falling edge.
    assign wr_evt = !cs_n && !wr_n && wr_n_q && wr_arm_q;

    always_comb begin
        wr_n_d    = wr_n;
        wr_arm_d  = wr_arm_q || wr_n;
        rd_flag_d = rd_req;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_n_q    <= 1'b1;
            wr_arm_q  <= 1'b0;
            rd_flag_q <= 1'b0;
        end else begin
            wr_n_q    <= wr_n_d;
            wr_arm_q  <= wr_arm_d;
            rd_flag_q <= rd_flag_d;
        end
    end

    assign rd_flag = rd_flag_q;

endmodule

// File: rtl/pic_cmd_sequencer.sv
// ICW1-4 initialization sequencer and OCW1-3 router for the PIC; outputs update on the write-event edge.
// Optional poll command support is enabled by defining PIC_POLL_EN.
module pic_cmd_sequencer
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cs_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] din,
    output logic       wr_flag,
    output logic       rd_flag,
    output logic [1:0] read_src,
    output logic       init_done,
    output logic       ic4,
    output logic       sngl,
    output logic       ltim,
    output logic [4:0] vector_base,
    output logic [7:0] icw3,
    output logic       upm,
    output logic       aeoi,
    output logic [7:0] imr,
    output logic       ocw2_pulse,
    output logic [2:0] ocw2_cmd,
    output logic [2:0] ocw2_level,
    output logic       poll_ack
);

    logic wr_evt, rd_req, is_icw1;

    pic_state_t state_q, state_d;

    logic       ic4_q, ic4_d, sngl_q, sngl_d, ltim_q, ltim_d;
    logic [4:0] vector_base_q, vector_base_d;
    logic [7:0] icw3_q, icw3_d, imr_q, imr_d;
    logic       upm_q, upm_d, aeoi_q, aeoi_d;
    logic       wr_flag_q, wr_flag_d;
    logic       ocw2_pulse_q, ocw2_pulse_d;
    logic [2:0] ocw2_cmd_q, ocw2_cmd_d, ocw2_level_q, ocw2_level_d;
    logic [1:0] sel_q, sel_d, read_src_q, read_src_d;
    logic       poll_pending_q, poll_pending_d;
    logic       poll_ack_q, poll_ack_d;

    pic_bus_strobe u_strobe (
        .clk     (clk),
        .reset   (reset),
        .cs_n    (cs_n),
        .rd_n    (rd_n),
        .wr_n    (wr_n),
        .wr_evt  (wr_evt),
        .rd_req  (rd_req),
        .rd_flag (rd_flag)
    );

    assign is_icw1 = wr_evt && !a0 && din[4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= UNINIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (is_icw1) begin
            state_d = WAIT_ICW2;
        end else if (wr_evt && a0) begin
            case (state_q)
                WAIT_ICW2: state_d = !sngl_q ? WAIT_ICW3 : (ic4_q ? WAIT_ICW4 : READY);
                WAIT_ICW3: state_d = ic4_q ? WAIT_ICW4 : READY;
                WAIT_ICW4: state_d = READY;
                default:   state_d = state_q;
            endcase
        end
    end

    always_comb begin
        init_done = (state_q == READY);
    end

    always_comb begin
        ic4_d          = ic4_q;
        sngl_d         = sngl_q;
        ltim_d         = ltim_q;
        vector_base_d  = vector_base_q;
        icw3_d         = icw3_q;
        upm_d          = upm_q;
        aeoi_d         = aeoi_q;
        imr_d          = imr_q;
        ocw2_cmd_d     = ocw2_cmd_q;
        ocw2_level_d   = ocw2_level_q;
        sel_d          = sel_q;
        poll_pending_d = poll_pending_q;
        wr_flag_d      = wr_evt;
        ocw2_pulse_d   = 1'b0;
        poll_ack_d     = 1'b0;

`ifdef PIC_POLL_EN
        if (rd_flag && !rd_req && poll_pending_q) begin
            poll_ack_d     = 1'b1;
            poll_pending_d = 1'b0;
        end
`endif

        if (is_icw1) begin
            ic4_d          = din[0];
            sngl_d         = din[1];
            ltim_d         = din[3];
            vector_base_d  = 5'd0;
            icw3_d         = 8'd0;
            upm_d          = 1'b0;
            aeoi_d         = 1'b0;
            imr_d          = 8'd0;
            sel_d          = RD_IRR;
            poll_pending_d = 1'b0;
        end else if (wr_evt) begin
            case (state_q)
                WAIT_ICW2: if (a0) vector_base_d = din[7:3];
                WAIT_ICW3: if (a0) icw3_d = din;
                WAIT_ICW4: begin
                    if (a0) begin
                        upm_d  = din[0];
                        aeoi_d = din[1];
                    end
                end
                READY: begin
                    if (a0) begin
                        imr_d = din;
                    end else if (din[4:3] == 2'b00) begin
                        ocw2_pulse_d = 1'b1;
                        ocw2_cmd_d   = din[7:5];
                        ocw2_level_d = din[2:0];
                    end else if (din[4:3] == 2'b01) begin
                        if (din[1]) sel_d = din[0] ? RD_ISR : RD_IRR;
`ifdef PIC_POLL_EN
                        if (din[2]) poll_pending_d = 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end

        // A read at a0=1 always returns the mask, even during a pending poll.
        if (rd_req && a0) begin
            read_src_d = RD_IMR;
        end else if (poll_pending_d) begin
            read_src_d = RD_POLL;
        end else begin
            read_src_d = sel_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ic4_q          <= 1'b0;
            sngl_q         <= 1'b0;
            ltim_q         <= 1'b0;
            vector_base_q  <= 5'd0;
            icw3_q         <= 8'd0;
            upm_q          <= 1'b0;
            aeoi_q         <= 1'b0;
            imr_q          <= 8'd0;
            ocw2_cmd_q     <= 3'd0;
            ocw2_level_q   <= 3'd0;
            sel_q          <= RD_IRR;
            poll_pending_q <= 1'b0;
            wr_flag_q      <= 1'b0;
            ocw2_pulse_q   <= 1'b0;
            poll_ack_q     <= 1'b0;
            read_src_q     <= RD_IRR;
        end else begin
            ic4_q          <= ic4_d;
            sngl_q         <= sngl_d;
            ltim_q         <= ltim_d;
            vector_base_q  <= vector_base_d;
            icw3_q         <= icw3_d;
            upm_q          <= upm_d;
            aeoi_q         <= aeoi_d;
            imr_q          <= imr_d;
            ocw2_cmd_q     <= ocw2_cmd_d;
            ocw2_level_q   <= ocw2_level_d;
            sel_q          <= sel_d;
            poll_pending_q <= poll_pending_d;
            wr_flag_q      <= wr_flag_d;
            ocw2_pulse_q   <= ocw2_pulse_d;
            poll_ack_q     <= poll_ack_d;
            read_src_q     <= read_src_d;
        end
    end

    assign wr_flag     = wr_flag_q;
    assign read_src    = read_src_q;
    assign ic4         = ic4_q;
    assign sngl        = sngl_q;
    assign ltim        = ltim_q;
    assign vector_base = vector_base_q;
    assign icw3        = icw3_q;
    assign upm         = upm_q;
    assign aeoi        = aeoi_q;
    assign imr         = imr_q;
    assign ocw2_pulse  = ocw2_pulse_q;
    assign ocw2_cmd    = ocw2_cmd_q;
    assign ocw2_level  = ocw2_level_q;
    assign poll_ack    = poll_ack_q;

endmodule
